vending_mach: RTL and testbench
===============================

// Module: vending_mach
// PURPOSE
//  Three-product coin-operated vending controller (Lemonwater 10, Sodabottle 20, Waterbottle 15 rupees).
//  Accepts 5/10-rupee coins after a product is chosen, dispenses when paid, returns change or refunds on cancel.
//  Tracks per-product stock loaded once after reset; sits between front-panel/coin-acceptor logic and the dispenser.
// PARAMETERS
//  PRICE_LEMON  10  price of Lemonwater (rupees, multiple of 5)
//  PRICE_SODA   20  price of Sodabottle
//  PRICE_WATER  15  price of Waterbottle
// PORTS
//  clk                    in  1  system clock, all state changes on rising edge
//  reset                  in  1  asynchronous, active-high reset
//  Fiverupee, Tenrupee    in  1  coin-inserted strobes (level, counted on rising edge)
//  Lemonwater, Sodabottle, Waterbottle  in 1  product-select buttons (rising edge)
//  cancel                 in  1  abort purchase and refund (level)
//  Lemonwater_added, Sodabottle_added, Waterbottle_added  in 5  initial stock counts
//  Lemonwater_available, Sodabottle_available, Waterbottle_available  out 5  current stock
//  coincount              out 5  rupees inserted for current purchase
//  product                out 2  00 none, 01 Lemonwater, 10 Sodabottle, 11 Waterbottle
//  give                   out 1  one-cycle dispense pulse
//  change                 out 5  change/refund amount, valid while in DISPENSE/REFUND
// BEHAVIOUR
//  - Reset (async, active-high): state=LOAD; all outputs 0; edge-detect history regs 0.
//  - All inputs synchronous to clk; coin/select inputs rising-edge detected via registered previous value.
//  - LOAD (1 cycle after reset release): each stock <= its *_added input; -> IDLE. Restock only via reset.
//  - IDLE: product=00, coincount=0, give=0, change=0. Coins ignored. Select edge for a product with
//    stock>0 -> COLLECT, product<=code. Multiple selects same cycle: Lemonwater > Sodabottle > Waterbottle.
//    Select of an out-of-stock product ignored.
//  - COLLECT: sum = coincount + 5*Five_edge + 10*Ten_edge (both edges same cycle add 15).
//    sum >= price -> DISPENSE on same edge: give<=1, change<=sum-price, coincount<=sum, stock of product -1.
//    Otherwise coincount<=sum. Further select edges ignored.
//  - cancel high in COLLECT (has priority over coins same cycle) -> REFUND: change<=coincount, give<=0,
//    product<=00. cancel in IDLE/LOAD ignored.
//  - DISPENSE / REFUND: held exactly 1 cycle, then IDLE with give, change, coincount, product cleared.
//  - Widths: max coincount 30 (15 held + 15 added), fits 5 bits; stock never decrements below 0 (guarded by select check).
//  - Reset mid-operation: inserted coins lost, no refund output; stock reloads in LOAD.
// STRUCTURE
//  - Shared package vm_pkg: state enum (LOAD, IDLE, COLLECT, DISPENSE, REFUND), product codes, coin values, default prices.
//  - One sub-module vm_stock_ctr (load, decrement, 5-bit count) instantiated once per product; FSM, coin
//    accumulator and edge detectors live in the top.
// TESTING
//  - Waterbottle_added=5, select Waterbottle, Ten then Five -> coincount 10 then 15, give=1 one cycle,
//    product=11, change=0, Waterbottle_available 5->4.
//  - Sodabottle (stock 2), Ten, Ten, Ten-with-Five same cycle not needed: Ten,Ten -> give, change=0; Ten,Five,Ten -> change=5.
//  - Lemonwater selected, Five then cancel -> REFUND cycle change=5, give=0, stock unchanged, back to IDLE.
//  - Select product with stock 0 -> stays IDLE, product=00; coins in IDLE -> coincount stays 0.
//  - Five and Ten same cycle for Waterbottle -> give, change=0; cancel same cycle as coin -> refund of prior coins only.
//  - Assert reset during COLLECT with coincount=10 -> all outputs 0 immediately, stock reloaded after release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and constants for the three-product vending controller.
package vm_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE,
        ST_REFUND
    } vm_state_t;

    localparam logic [1:0] PROD_NONE  = 2'b00;
    localparam logic [1:0] PROD_LEMON = 2'b01;
    localparam logic [1:0] PROD_SODA  = 2'b10;
    localparam logic [1:0] PROD_WATER = 2'b11;

    localparam logic [5:0] COIN_FIVE = 6'd5;
    localparam logic [5:0] COIN_TEN  = 6'd10;

    localparam int DEF_PRICE_LEMON = 10;
    localparam int DEF_PRICE_SODA  = 20;
    localparam int DEF_PRICE_WATER = 15;

    // Simultaneous selects resolve Lemonwater, then Sodabottle, then Waterbottle.
    function automatic logic [1:0] pick_product(input logic lemon, input logic soda,
                                                input logic water);
        logic [1:0] code;
        if (lemon)
            code = PROD_LEMON;
        else if (soda)
            code = PROD_SODA;
        else if (water)
            code = PROD_WATER;
        else
            code = PROD_NONE;
        return code;
    endfunction

endpackage

// File: rtl/vm_stock_ctr.sv
// Per-product stock counter: loaded once after reset, decremented on each dispense.
module vm_stock_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [4:0] load_val,
    output logic [4:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= 5'd0;
        else if (load)
            count <= load_val;
        else if (dec && (count != 5'd0))
            count <= count - 5'd1;
    end

endmodule

// File: rtl/vending_mach.sv
// Coin-operated vending controller: product select, coin accumulation, dispense/refund.
//  state    | meaning
//  LOAD     | one cycle after reset, copy initial stock counts
//  IDLE     | waiting for a select of an in-stock product
//  COLLECT  | accumulating coins for the chosen product
//  DISPENSE | give pulse, change presented for one cycle
//  REFUND   | inserted coins returned as change for one cycle
module vending_mach
    import vm_pkg::*;
#(
    parameter int PRICE_LEMON = DEF_PRICE_LEMON,
    parameter int PRICE_SODA  = DEF_PRICE_SODA,
    parameter int PRICE_WATER = DEF_PRICE_WATER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Fiverupee,
    input  logic       Tenrupee,
    input  logic       Lemonwater,
    input  logic       Sodabottle,
    input  logic       Waterbottle,
    input  logic       cancel,
    input  logic [4:0] Lemonwater_added,
    input  logic [4:0] Sodabottle_added,
    input  logic [4:0] Waterbottle_added,
    output logic [4:0] Lemonwater_available,
    output logic [4:0] Sodabottle_available,
    output logic [4:0] Waterbottle_available,
    output logic [4:0] coincount,
    output logic [1:0] product,
    output logic       give,
    output logic [4:0] change
);

    localparam logic [5:0] P_LEMON = 6'(PRICE_LEMON);
    localparam logic [5:0] P_SODA  = 6'(PRICE_SODA);
    localparam logic [5:0] P_WATER = 6'(PRICE_WATER);

    vm_state_t  state, state_nxt;
    logic       five_q, ten_q, lemon_q, soda_q, water_q;
    logic       five_e, ten_e, lemon_e, soda_e, water_e;
    logic [1:0] sel_code;
    logic [5:0] price, sum;
    logic       paid;
    logic [4:0] coincount_nxt, change_nxt;
    logic [1:0] product_nxt;
    logic       give_nxt;
    logic       stock_load, dec_lemon, dec_soda, dec_water;

    assign five_e  = Fiverupee   & ~five_q;
    assign ten_e   = Tenrupee    & ~ten_q;
    assign lemon_e = Lemonwater  & ~lemon_q;
    assign soda_e  = Sodabottle  & ~soda_q;
    assign water_e = Waterbottle & ~water_q;

    // Out-of-stock selects are masked before priority so they never block a valid one.
    assign sel_code = pick_product(lemon_e & (Lemonwater_available != 5'd0),
                                   soda_e  & (Sodabottle_available != 5'd0),
                                   water_e & (Waterbottle_available != 5'd0));

    always_comb begin
        price = 6'h3F;
        case (product)
            PROD_LEMON: price = P_LEMON;
            PROD_SODA:  price = P_SODA;
            PROD_WATER: price = P_WATER;
            default:    price = 6'h3F;
        endcase
    end

    assign sum  = {1'b0, coincount} + (five_e ? COIN_FIVE : 6'd0) + (ten_e ? COIN_TEN : 6'd0);
    assign paid = (sum >= price);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_LOAD;
            five_q    <= 1'b0;
            ten_q     <= 1'b0;
            lemon_q   <= 1'b0;
            soda_q    <= 1'b0;
            water_q   <= 1'b0;
            coincount <= 5'd0;
            change    <= 5'd0;
            product   <= PROD_NONE;
            give      <= 1'b0;
        end else begin
            state     <= state_nxt;
            five_q    <= Fiverupee;
            ten_q     <= Tenrupee;
            lemon_q   <= Lemonwater;
            soda_q    <= Sodabottle;
            water_q   <= Waterbottle;
            coincount <= coincount_nxt;
            change    <= change_nxt;
            product   <= product_nxt;
            give      <= give_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:     state_nxt = ST_IDLE;
            ST_IDLE:     if (sel_code != PROD_NONE) state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (cancel)
                    state_nxt = ST_REFUND;
                else if (paid)
                    state_nxt = ST_DISPENSE;
            end
            ST_DISPENSE: state_nxt = ST_IDLE;
            ST_REFUND:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        coincount_nxt = 5'd0;
        change_nxt    = 5'd0;
        product_nxt   = PROD_NONE;
        give_nxt      = 1'b0;
        stock_load    = 1'b0;
        dec_lemon     = 1'b0;
        dec_soda      = 1'b0;
        dec_water     = 1'b0;
        case (state)
            ST_LOAD: stock_load = 1'b1;
            ST_IDLE: product_nxt = sel_code;
            ST_COLLECT: begin
                if (cancel) begin
                    // Coins arriving with cancel are not counted; only prior coins come back.
                    coincount_nxt = coincount;
                    change_nxt    = coincount;
                end else begin
                    coincount_nxt = sum[4:0];
                    product_nxt   = product;
                    if (paid) begin
                        give_nxt   = 1'b1;
                        change_nxt = 5'(sum - price);
                        dec_lemon  = (product == PROD_LEMON);
                        dec_soda   = (product == PROD_SODA);
                        dec_water  = (product == PROD_WATER);
                    end
                end
            end
            default: ;
        endcase
    end

    vm_stock_ctr u_stock_lemon (
        .clk      (clk),
        .reset    (reset),
        .load     (stock_load),
        .dec      (dec_lemon),
        .load_val (Lemonwater_added),
        .count    (Lemonwater_available)
    );

    vm_stock_ctr u_stock_soda (
        .clk      (clk),
        .reset    (reset),
        .load     (stock_load),
        .dec      (dec_soda),
        .load_val (Sodabottle_added),
        .count    (Sodabottle_available)
    );

    vm_stock_ctr u_stock_water (
        .clk      (clk),
        .reset    (reset),
        .load     (stock_load),
        .dec      (dec_water),
        .load_val (Waterbottle_added),
        .count    (Waterbottle_available)
    );

endmodule

// File: tb/tb_vending_mach.sv
// Table-driven directed vectors plus randomized traffic against a purchase-level model.
module tb_vending_mach;

    logic       clk = 1'b0;
    logic       reset;
    logic       Fiverupee, Tenrupee, Lemonwater, Sodabottle, Waterbottle, cancel;
    logic [4:0] Lemonwater_added, Sodabottle_added, Waterbottle_added;
    logic [4:0] Lemonwater_available, Sodabottle_available, Waterbottle_available;
    logic [4:0] coincount, change;
    logic [1:0] product;
    logic       give;

    vending_mach dut (
        .clk                   (clk),
        .reset                 (reset),
        .Fiverupee             (Fiverupee),
        .Tenrupee              (Tenrupee),
        .Lemonwater            (Lemonwater),
        .Sodabottle            (Sodabottle),
        .Waterbottle           (Waterbottle),
        .cancel                (cancel),
        .Lemonwater_added      (Lemonwater_added),
        .Sodabottle_added      (Sodabottle_added),
        .Waterbottle_added     (Waterbottle_added),
        .Lemonwater_available  (Lemonwater_available),
        .Sodabottle_available  (Sodabottle_available),
        .Waterbottle_available (Waterbottle_available),
        .coincount             (coincount),
        .product               (product),
        .give                  (give),
        .change                (change)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // inp = {five, ten, lemon, soda, water, cancel}
    typedef struct {
        bit [5:0] inp;
        int cc, prod, give, chg, sl, ss, sw;
    } vec_t;
    vec_t vecs[$];

    // Reference model: purchase-level view, products indexed 1..3 (= product code).
    int m_phase;   // 0 awaiting stock load, 1 idle, 2 collecting, 3 result shown
    int m_cc, m_prod, m_give, m_chg;
    int m_stock[1:3];
    int m_price[1:3] = '{10, 20, 15};
    bit p_in[6];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int cc, input int prod, input int gv,
                             input int chg, input int sl, input int ss, input int sw);
        cmp({tag, ".coincount"}, int'(coincount), cc);
        cmp({tag, ".product"}, int'(product), prod);
        cmp({tag, ".give"}, int'(give), gv);
        cmp({tag, ".change"}, int'(change), chg);
        cmp({tag, ".lemon_avail"}, int'(Lemonwater_available), sl);
        cmp({tag, ".soda_avail"}, int'(Sodabottle_available), ss);
        cmp({tag, ".water_avail"}, int'(Waterbottle_available), sw);
    endtask

    task automatic drive(input bit [5:0] v);
        {Fiverupee, Tenrupee, Lemonwater, Sodabottle, Waterbottle, cancel} = v;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cc = 0; m_prod = 0; m_give = 0; m_chg = 0;
        for (int k = 1; k <= 3; k++) m_stock[k] = 0;
        for (int k = 0; k < 6; k++) p_in[k] = 1'b0;
    endtask

    task automatic model_clock();
        bit cur[6];
        bit e[6];
        bit found;
        cur = '{Fiverupee, Tenrupee, Lemonwater, Sodabottle, Waterbottle, cancel};
        for (int k = 0; k < 6; k++) e[k] = cur[k] && !p_in[k];
        for (int k = 0; k < 5; k++) p_in[k] = cur[k];
        case (m_phase)
            0: begin
                m_stock[1] = Lemonwater_added;
                m_stock[2] = Sodabottle_added;
                m_stock[3] = Waterbottle_added;
                m_phase = 1;
            end
            1: begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++)
                    if (!found && e[k+1] && m_stock[k] > 0) begin
                        found = 1'b1;
                        m_prod = k;
                        m_phase = 2;
                    end
            end
            2: begin
                if (cur[5]) begin
                    m_chg = m_cc;
                    m_prod = 0;
                    m_phase = 3;
                end else begin
                    m_cc += (e[0] ? 5 : 0) + (e[1] ? 10 : 0);
                    if (m_cc >= m_price[m_prod]) begin
                        m_give = 1;
                        m_chg = m_cc - m_price[m_prod];
                        m_stock[m_prod]--;
                        m_phase = 3;
                    end
                end
            end
            default: begin
                m_cc = 0; m_prod = 0; m_give = 0; m_chg = 0;
                m_phase = 1;
            end
        endcase
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] al, input logic [4:0] as, input logic [4:0] aw);
        Lemonwater_added = al;
        Sodabottle_added = as;
        Waterbottle_added = aw;
        drive(6'b0);
        reset = 1'b1;
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic add_vec(input bit [5:0] inp, input int cc, input int prod, input int gv,
                           input int chg, input int sl, input int ss, input int sw);
        vec_t v;
        v.inp = inp; v.cc = cc; v.prod = prod; v.give = gv; v.chg = chg;
        v.sl = sl; v.ss = ss; v.sw = sw;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        drive(6'b0);
        Lemonwater_added = '0; Sodabottle_added = '0; Waterbottle_added = '0;

        //      five,ten,l,s,w,cancel   cc prod give chg  L  S  W
        add_vec(6'b000010,  0, 3, 0,  0, 3, 2, 5);
        add_vec(6'b010000, 10, 3, 0,  0, 3, 2, 5);
        add_vec(6'b100000, 15, 3, 1,  0, 3, 2, 4);
        add_vec(6'b000000,  0, 0, 0,  0, 3, 2, 4);
        add_vec(6'b000100,  0, 2, 0,  0, 3, 2, 4);
        add_vec(6'b010000, 10, 2, 0,  0, 3, 2, 4);
        add_vec(6'b000000, 10, 2, 0,  0, 3, 2, 4);
        add_vec(6'b010000, 20, 2, 1,  0, 3, 1, 4);
        add_vec(6'b000000,  0, 0, 0,  0, 3, 1, 4);
        add_vec(6'b000100,  0, 2, 0,  0, 3, 1, 4);
        add_vec(6'b010000, 10, 2, 0,  0, 3, 1, 4);
        add_vec(6'b100000, 15, 2, 0,  0, 3, 1, 4);
        add_vec(6'b010000, 25, 2, 1,  5, 3, 0, 4);
        add_vec(6'b000000,  0, 0, 0,  0, 3, 0, 4);
        add_vec(6'b000100,  0, 0, 0,  0, 3, 0, 4);
        add_vec(6'b100000,  0, 0, 0,  0, 3, 0, 4);
        add_vec(6'b010000,  0, 0, 0,  0, 3, 0, 4);
        add_vec(6'b001000,  0, 1, 0,  0, 3, 0, 4);
        add_vec(6'b100000,  5, 1, 0,  0, 3, 0, 4);
        add_vec(6'b000001,  5, 0, 0,  5, 3, 0, 4);
        add_vec(6'b000000,  0, 0, 0,  0, 3, 0, 4);
        add_vec(6'b000010,  0, 3, 0,  0, 3, 0, 4);
        add_vec(6'b110000, 15, 3, 1,  0, 3, 0, 3);
        add_vec(6'b000000,  0, 0, 0,  0, 3, 0, 3);
        add_vec(6'b000010,  0, 3, 0,  0, 3, 0, 3);
        add_vec(6'b010000, 10, 3, 0,  0, 3, 0, 3);
        add_vec(6'b100001, 10, 0, 0, 10, 3, 0, 3);
        add_vec(6'b000000,  0, 0, 0,  0, 3, 0, 3);
        add_vec(6'b001110,  0, 1, 0,  0, 3, 0, 3);
        add_vec(6'b000001,  0, 0, 0,  0, 3, 0, 3);
        add_vec(6'b000000,  0, 0, 0,  0, 3, 0, 3);

        do_reset(5'd3, 5'd2, 5'd5);
        step();
        check_all("load", 0, 0, 0, 0, 3, 2, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].inp);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].cc, vecs[i].prod, vecs[i].give,
                      vecs[i].chg, vecs[i].sl, vecs[i].ss, vecs[i].sw);
        end

        // Asynchronous reset while collecting with 10 rupees held.
        drive(6'b000010);
        step();
        drive(6'b010000);
        step();
        check_all("pre_reset", 10, 3, 0, 0, 3, 0, 3);
        drive(6'b000000);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        check_all("reload", 0, 0, 0, 0, 3, 2, 5);

        for (int r = 0; r < 40; r++) begin
            do_reset(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)));
            for (int c = 0; c < 60; c++) begin
                Fiverupee   = ($urandom_range(0, 2) == 0);
                Tenrupee    = ($urandom_range(0, 2) == 0);
                Lemonwater  = ($urandom_range(0, 3) == 0);
                Sodabottle  = ($urandom_range(0, 3) == 0);
                Waterbottle = ($urandom_range(0, 3) == 0);
                cancel      = ($urandom_range(0, 9) == 0);
                step();
                check_all($sformatf("rnd%0d_%0d", r, c), m_cc, m_prod, m_give, m_chg,
                          m_stock[1], m_stock[2], m_stock[3]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
